fifo_stream_rdr: RTL



---
 rtl/fifo_stream_rdr_pkg.sv | 18 +
 rtl/fifo_stream_rdr_buf.sv | 63 ++++++
 rtl/fifo_stream_rdr.sv | 114 +++++++++++
 3 files changed

// File: rtl/fifo_stream_rdr_pkg.sv
// fifo_stream_rdr_pkg
// Shared constants and helpers for the fifo_stream_rdr block.
//   BEAT_CNT_W : width of the packet beat counter
//   STAT_CNT_W : width of the optional statistics counters
//   buf_dep()  : internal skid-buffer depth for a given fifo read mode
package fifo_stream_rdr_pkg;

  localparam int unsigned BEAT_CNT_W = 16;
  localparam int unsigned STAT_CNT_W = 16;

  // FWFT fifos deliver data in the read cycle (one register stage is enough
  // to cover the read-issue pipeline); standard fifos need one more slot for
  // the word that is still in flight.
  function automatic int unsigned buf_dep(input int unsigned fwft);
    return (fwft != 0) ? 32'd2 : 32'd3;
  endfunction

endpackage

// File: rtl/fifo_stream_rdr_buf.sv
// fifo_stream_rdr_buf
// Small circular buffer used to absorb the fifo read latency.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   wr        : push wr_data (caller guarantees not full)
//   wr_data   : data to push
//   rd        : pop head entry (caller guarantees not empty)
//   rd_data   : head entry (meaningful while occ != 0)
//   occ       : number of stored entries, 0..DEP
module fifo_stream_rdr_buf #(
  parameter  int unsigned DWIDTH = 8,
  parameter  int unsigned DEP    = 2,
  localparam int unsigned OW     = $clog2(DEP + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd,
  output logic [DWIDTH-1:0] rd_data,
  output logic [OW-1:0]     occ
);

  localparam int unsigned PW = $clog2(DEP);

  logic [DWIDTH-1:0] mem [DEP];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  // DEP need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEP - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (rd) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({wr, rd})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_comb rd_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_rdr.sv
// fifo_stream_rdr
// Drains the read port of a `fifo` (FWFT or standard mode) and presents the
// words as a valid/ready master stream with packet framing (m_last_o on beat
// BURST_LEN-1). Reads are issued from registered occupancy only, so m_ready_i
// has no combinational path to fifo_rd_o.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (shared with fifo)
//   fifo_data_i   : fifo data_o
//   fifo_empty_i  : fifo empty_o
//   fifo_rd_o     : fifo rd
//   m_data_o      : stream data (0 while not valid)
//   m_valid_o     : stream valid
//   m_ready_i     : stream ready
//   m_last_o      : last beat of packet
// Optional (macro FIFO_STREAM_RDR_STATS_EN):
//   stall_cnt_o   : cycles with valid && !ready, saturating
//   pkt_cnt_o     : completed packets (last handshakes), wrapping
module fifo_stream_rdr
  import fifo_stream_rdr_pkg::*;
#(
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned FWFT      = 1,
  parameter int unsigned BURST_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DWIDTH-1:0]     fifo_data_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_o,
  output logic [DWIDTH-1:0]     m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o
`ifdef FIFO_STREAM_RDR_STATS_EN
  ,
  output logic [STAT_CNT_W-1:0] stall_cnt_o,
  output logic [STAT_CNT_W-1:0] pkt_cnt_o
`endif
);

  localparam int unsigned BUF_DEP = buf_dep(FWFT);
  localparam int unsigned OW      = $clog2(BUF_DEP + 1);
  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BURST_LEN - 1);

  logic [OW-1:0]         occ;
  logic                  inflight;
  logic                  buf_wr;
  logic                  pop;
  logic [DWIDTH-1:0]     head;
  logic [BEAT_CNT_W-1:0] beat_cnt;

  // A slot is reserved for every word already read but not yet delivered.
  always_comb begin
    fifo_rd_o = !rst && !fifo_empty_i &&
                (({1'b0, occ} + (OW + 1)'(inflight)) < (OW + 1)'(BUF_DEP));
  end

  always_comb buf_wr = (FWFT != 0) ? fifo_rd_o : inflight;

  // Standard-mode data lands the cycle after rd; reset clears the flag so a
  // word arriving just after reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= (FWFT == 0) && fifo_rd_o;
    end
  end

  fifo_stream_rdr_buf #(
    .DWIDTH (DWIDTH),
    .DEP    (BUF_DEP)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr      (buf_wr),
    .wr_data (fifo_data_i),
    .rd      (pop),
    .rd_data (head),
    .occ     (occ)
  );

  always_comb begin
    m_valid_o = (occ != '0);
    pop       = m_valid_o && m_ready_i;
    m_data_o  = m_valid_o ? head : '0;
    m_last_o  = m_valid_o && (beat_cnt == LAST_BEAT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
    end
  end

`ifdef FIFO_STREAM_RDR_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= '0;
      pkt_cnt_o   <= '0;
    end else begin
      if (m_valid_o && !m_ready_i && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + 1'b1;
      end
      if (pop && m_last_o) begin
        pkt_cnt_o <= pkt_cnt_o + 1'b1;
      end
    end
  end
`endif

endmodule
